// File: rtl/serial_tx_8b.sv
// ---------------------------------------------------------------------------
// serial_tx_8b
//
// Parallel-to-serial frame transmitter. A word accepted on din is sent on
// sout as one start bit (0), WIDTH data bits and one stop bit (1). Each bit
// is held for CLKS_PER_BIT clock cycles. The line idles high.
//
// Parameters
//   WIDTH        data word width in bits (2..16)
//   CLKS_PER_BIT clock cycles per serial bit (1..255)
//   MSB_FIRST    0 = least significant bit first, 1 = most significant first
//
// Ports
//   clk    in   single clock, all state changes on its rising edge
//   reset  in   asynchronous, active-low reset
//   din    in   parallel word, sampled only when a load is accepted
//   load   in   request to transmit din
//   ready  out  a load will be accepted at the next rising edge
//   sout   out  registered serial line output, idle high
//   done   out  one-cycle pulse in the final cycle of the stop bit
// ---------------------------------------------------------------------------
module serial_tx_8b #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int MSB_FIRST    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             done
);

    // The bit-period counter needs at least one bit even when a serial bit
    // lasts a single clock, in which case it simply stays at zero.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(WIDTH);

    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    bit_cnt;
    logic [IW-1:0]    bit_idx;
    logic [WIDTH-1:0] shreg;
    logic             sout_q;

    logic             bit_end;
    logic             stop_last;
    logic             accept;
    logic             next_bit;
    logic [WIDTH-1:0] shreg_shifted;

    // Status decode from registered state only. The final stop cycle is the
    // one place a frame both completes and can accept the next word, which
    // is what allows back-to-back frames with no idle gap.
    always_comb begin
        bit_end   = (bit_cnt == CNT_MAX);
        stop_last = (state == ST_STOP) && bit_end;
        ready     = (state == ST_IDLE) || stop_last;
        done      = stop_last;
        accept    = load && ready;
    end

    // Select the bit that leaves the shift register next and the register
    // contents after it has been consumed. The register always shifts
    // towards the output end, so the data index only counts bits and never
    // addresses the word directly.
    always_comb begin
        next_bit      = 1'b0;
        shreg_shifted = '0;
        if (MSB_FIRST != 0) begin
            next_bit      = shreg[WIDTH-1];
            shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            next_bit      = shreg[0];
            shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    // Frame sequencer. sout is loaded together with each state change so the
    // line value for a bit appears in the first cycle of that bit and comes
    // straight from a flop, with no path from load or din.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            sout_q  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    if (accept) begin
                        shreg  <= din;
                        state  <= ST_START;
                        sout_q <= 1'b0;
                    end else begin
                        sout_q <= 1'b1;
                    end
                end

                ST_START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                        sout_q  <= next_bit;
                        shreg   <= shreg_shifted;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == IDX_MAX) begin
                            bit_idx <= '0;
                            state   <= ST_STOP;
                            sout_q  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            sout_q  <= next_bit;
                            shreg   <= shreg_shifted;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (accept) begin
                            shreg  <= din;
                            state  <= ST_START;
                            sout_q <= 1'b0;
                        end else begin
                            state  <= ST_IDLE;
                            sout_q <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    sout_q  <= 1'b1;
                end
            endcase
        end
    end

    assign sout = sout_q;

endmodule

// File: tb/tb_serial_tx_8b.sv
// ---------------------------------------------------------------------------
// tb_serial_tx_8b
//
// Directed bench for serial_tx_8b. dut0 uses the default configuration
// (WIDTH=8, CLKS_PER_BIT=4, LSB first); dut1 uses CLKS_PER_BIT=1 and MSB
// first. Expected line values come from the frame format: cycle c after the
// accepting edge carries slot (c-1)/CLKS_PER_BIT, where slot 0 is the start
// bit, slots 1..8 the data bits and slot 9 the stop bit.
// ---------------------------------------------------------------------------
module tb_serial_tx_8b;

    logic       clk;
    logic       reset;

    logic [7:0] din0;
    logic       load0;
    logic       ready0;
    logic       sout0;
    logic       done0;

    logic [7:0] din1;
    logic       load1;
    logic       ready1;
    logic       sout1;
    logic       done1;

    int check_count;
    int error_count;

    serial_tx_8b #(
        .WIDTH       (8),
        .CLKS_PER_BIT(4),
        .MSB_FIRST   (0)
    ) dut0 (
        .clk  (clk),
        .reset(reset),
        .din  (din0),
        .load (load0),
        .ready(ready0),
        .sout (sout0),
        .done (done0)
    );

    serial_tx_8b #(
        .WIDTH       (8),
        .CLKS_PER_BIT(1),
        .MSB_FIRST   (1)
    ) dut1 (
        .clk  (clk),
        .reset(reset),
        .din  (din1),
        .load (load1),
        .ready(ready1),
        .sout (sout1),
        .done (done1)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line value in cycle c after the accepting edge.
    function automatic logic expSout(input logic [7:0] w, input int c,
                                     input int k, input bit msb);
        int slot;
        slot = (c - 1) / k;
        if (slot == 0) return 1'b0;
        if (slot >= 9) return 1'b1;
        if (msb) return w[8 - slot];
        return w[slot - 1];
    endfunction

    // Walk dut0 through a frame starting in cycle 1 and ending in cycle
    // lastCycle (40 for a full frame). If pulseAt is nonzero, load is
    // pulsed for one cycle at that cycle with an unrelated din.
    task automatic applyStimulus(input string tag, input logic [7:0] word,
                                 input int pulseAt, input int lastCycle);
        for (int c = 1; c <= lastCycle; c++) begin
            checkOutput({tag, " sout"}, 32'(sout0), 32'(expSout(word, c, 4, 1'b0)));
            checkOutput({tag, " ready"}, 32'(ready0), 32'(c == 40));
            checkOutput({tag, " done"}, 32'(done0), 32'(c == 40));
            if (pulseAt != 0) begin
                if (c == pulseAt) begin
                    load0 = 1'b1;
                    din0  = 8'h00;
                end else begin
                    load0 = 1'b0;
                end
            end
            if (c < lastCycle) step();
        end
    endtask

    // Check dut0 sits idle for n cycles.
    task automatic checkIdle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, " sout"}, 32'(sout0), 32'd1);
            checkOutput({tag, " ready"}, 32'(ready0), 32'd1);
            checkOutput({tag, " done"}, 32'(done0), 32'd0);
            step();
        end
    endtask

    // Run a full frame on dut1 (one clock per bit, MSB first).
    task automatic checkFast(input string tag, input logic [7:0] word);
        din1  = word;
        load1 = 1'b1;
        step();
        load1 = 1'b0;
        din1  = ~word;
        for (int c = 1; c <= 10; c++) begin
            checkOutput({tag, " sout"}, 32'(sout1), 32'(expSout(word, c, 1, 1'b1)));
            checkOutput({tag, " done"}, 32'(done1), 32'(c == 10));
            checkOutput({tag, " ready"}, 32'(ready1), 32'(c == 10));
            step();
        end
        checkOutput({tag, " idle sout"}, 32'(sout1), 32'd1);
        checkOutput({tag, " idle done"}, 32'(done1), 32'd0);
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        reset = 1'b0;
        load0 = 1'b0;
        din0  = 8'h00;
        load1 = 1'b0;
        din1  = 8'h00;

        // Reset state, then 20 idle cycles with load low.
        #12;
        checkOutput("reset sout", 32'(sout0), 32'd1);
        checkOutput("reset ready", 32'(ready0), 32'd1);
        checkOutput("reset done", 32'(done0), 32'd0);
        step();
        #2 reset = 1'b1;
        step();
        checkIdle("post-reset idle", 20);

        // Plain A5 frame; din changes right after acceptance.
        $display("[TB] frame 8'hA5");
        din0  = 8'hA5;
        load0 = 1'b1;
        step();
        load0 = 1'b0;
        din0  = 8'h00;
        applyStimulus("A5", 8'hA5, 0, 40);
        step();
        checkIdle("after A5", 4);

        // Back-to-back: 3C, then FF accepted in the final stop cycle.
        $display("[TB] back-to-back 8'h3C then 8'hFF");
        din0  = 8'h3C;
        load0 = 1'b1;
        step();
        din0  = 8'hFF;
        applyStimulus("3C", 8'h3C, 0, 40);
        step();
        load0 = 1'b0;
        applyStimulus("FF", 8'hFF, 0, 40);
        step();
        checkIdle("after FF", 4);

        // Load pulsed while busy must be ignored.
        $display("[TB] busy load ignored");
        din0  = 8'hA5;
        load0 = 1'b1;
        step();
        load0 = 1'b0;
        applyStimulus("busy", 8'hA5, 10, 40);
        step();
        checkIdle("no second frame", 8);

        // Reset in cycle 17 aborts the frame asynchronously.
        $display("[TB] mid-frame reset");
        din0  = 8'hC3;
        load0 = 1'b1;
        step();
        load0 = 1'b0;
        applyStimulus("abort", 8'hC3, 0, 17);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort async sout", 32'(sout0), 32'd1);
        checkOutput("abort async ready", 32'(ready0), 32'd1);
        checkOutput("abort async done", 32'(done0), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("abort hold sout", 32'(sout0), 32'd1);
            checkOutput("abort hold done", 32'(done0), 32'd0);
        end
        #2 reset = 1'b1;
        step();
        checkIdle("after abort", 30);
        din0  = 8'h5A;
        load0 = 1'b1;
        step();
        load0 = 1'b0;
        applyStimulus("5A", 8'h5A, 0, 40);
        step();
        checkIdle("after 5A", 2);

        // One clock per bit, MSB first.
        $display("[TB] CLKS_PER_BIT=1 MSB first");
        checkFast("fast A5", 8'hA5);
        checkFast("fast 01", 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
